// File: rtl/m_proc_mc.sv
// m_proc_mc: multi-cycle RV32I-subset core (ADD, SUB, ADDI, LUI, JAL, BEQ, BNE, LW, SW).
// Each instruction walks IF -> ID -> EX -> MEM -> WB, and one ALU is shared by all states.
// The instruction and data memories are internal; the bench loads `imem` hierarchically.
// Build option: define PROC_MC_EARLY_RETIRE_EN to let an instruction retire in the
// first state where it has finished its work.
module m_proc_mc #(
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_WORDS = 64,
   parameter int unsigned HALT_REG   = 30
) (
   input  logic        w_clk,
   input  logic        w_rst,
   output logic [31:0] w_pc,
   output logic        w_retire,
   output logic        w_wb_we,
   output logic [4:0]  w_rd_idx,
   output logic [31:0] w_wb_data,
   output logic        w_halt
);

   localparam int unsigned ImemAw = $clog2(IMEM_WORDS);
   localparam int unsigned DmemAw = $clog2(DMEM_WORDS);
   localparam logic [4:0]  HaltIdx = 5'(HALT_REG);
`ifdef PROC_MC_EARLY_RETIRE_EN
   localparam bit EarlyRetire = 1'b1;
`else
   localparam bit EarlyRetire = 1'b0;
`endif

   typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, ipc_q, ipc_d, ir_q, ir_d;
   logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] rf_q [32];

   logic [ImemAw-1:0] imem_idx;
   logic [DmemAw-1:0] dmem_idx;
   assign imem_idx = pc_q[ImemAw+1:2];
   assign dmem_idx = alu_out_q[DmemAw+1:2];

   // Instruction fields and decode
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic is_add, is_sub, is_addi, is_lui, is_jal, is_beq, is_bne, is_lw, is_sw;
   logic is_branch, writes_rd;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];

   // Decode opcode and build the format-specific sign-extended immediate
   always_comb begin
      is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
      is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
      is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
      is_lui  = (opcode == 7'b0110111);
      is_jal  = (opcode == 7'b1101111);
      is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
      is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
      is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
      is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
      is_branch = is_beq | is_bne;
      writes_rd = is_add | is_sub | is_addi | is_lui | is_jal | is_lw;
      imm = {{20{ir_q[31]}}, ir_q[31:20]};
      if (is_sw) begin
         imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end else if (is_branch) begin
         imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end else if (is_lui) begin
         imm = {ir_q[31:12], 12'b0};
      end else if (is_jal) begin
         imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
   end

   // Shared ALU: operand selection by instruction; branches compare via subtraction
   logic [31:0] alu_a, alu_b, alu_res;
   logic        alu_sub, br_taken;
   always_comb begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sub = is_sub | is_branch;
      if (is_addi || is_lw || is_sw) begin
         alu_b = imm;
      end else if (is_lui) begin
         alu_a = '0;
         alu_b = imm;
      end else if (is_jal) begin
         alu_a = ipc_q;
         alu_b = 32'd4;
      end
      alu_res  = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
      br_taken = (is_beq && (alu_res == 32'd0)) || (is_bne && (alu_res != 32'd0));
   end

   // Writeback and store enables; reset blocks the store in the same cycle
   logic        rf_we, dmem_we;
   logic [31:0] wb_data;
   assign wb_data = is_lw ? mdr_q : alu_out_q;
   assign rf_we   = (state_q == StWb) && writes_rd && (rd != 5'd0);
   assign dmem_we = (state_q == StMem) && is_sw && !w_rst;

   // Next-state, datapath register updates per FSM state
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ipc_d     = ipc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      mdr_d     = mdr_q;
      unique case (state_q)
         StIf: begin
            ir_d    = imem[imem_idx];
            ipc_d   = pc_q;
            state_d = StId;
         end
         StId: begin
            a_d     = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
            b_d     = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
            state_d = StEx;
         end
         StEx: begin
            if (!is_branch) begin
               alu_out_d = alu_res;
            end
            pc_d = ipc_q + ((br_taken || is_jal) ? imm : 32'd4);
            if (!EarlyRetire || is_lw || is_sw) begin
               state_d = StMem;
            end else if (is_branch) begin
               state_d = StIf;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (is_lw) begin
               mdr_d = dmem[dmem_idx];
            end
            state_d = (EarlyRetire && is_sw) ? StIf : StWb;
         end
         StWb: begin
            state_d = (rf_we && (rd == HaltIdx)) ? StHalt : StIf;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIf;
         end
      endcase
   end

   // Core state registers with synchronous reset
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q   <= StIf;
         pc_q      <= '0;
         ipc_q     <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         mdr_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ipc_q     <= ipc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         mdr_q     <= mdr_d;
      end
   end

   // Register file; x0 is never written so it always reads zero
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_we) begin
         rf_q[rd] <= wb_data;
      end
   end

   // Data memory write port; contents survive reset
   always_ff @(posedge w_clk) begin
      if (dmem_we) begin
         dmem[dmem_idx] <= b_q;
      end
   end

   // Outputs: outside IF the in-flight address is the latched instruction pc
   always_comb begin
      w_pc      = (state_q == StIf) ? pc_q : ipc_q;
      w_retire  = (state_q == StWb) ||
                  (EarlyRetire && (((state_q == StEx) && is_branch) ||
                                   ((state_q == StMem) && is_sw)));
      w_wb_we   = rf_we;
      w_rd_idx  = rf_we ? rd : 5'd0;
      w_wb_data = rf_we ? wb_data : 32'd0;
      w_halt    = (state_q == StHalt);
   end

endmodule

// File: tb/tb_m_proc_mc.sv
// tb_m_proc_mc: scoreboard bench for m_proc_mc. Expected retirements (pc, latency,
// writeback) are queued as each program is loaded and popped on every w_retire.
module tb_m_proc_mc;

`ifdef PROC_MC_EARLY_RETIRE_EN
   localparam int LatAlu = 4;
   localparam int LatBr  = 3;
   localparam int LatSw  = 4;
`else
   localparam int LatAlu = 5;
   localparam int LatBr  = 5;
   localparam int LatSw  = 5;
`endif
   localparam int LatLw = 5;

   logic        w_clk = 1'b0;
   logic        w_rst = 1'b1;
   logic [31:0] w_pc, w_wb_data;
   logic        w_retire, w_wb_we, w_halt;
   logic [4:0]  w_rd_idx;

   m_proc_mc dut (
      .w_clk     (w_clk),
      .w_rst     (w_rst),
      .w_pc      (w_pc),
      .w_retire  (w_retire),
      .w_wb_we   (w_wb_we),
      .w_rd_idx  (w_rd_idx),
      .w_wb_data (w_wb_data),
      .w_halt    (w_halt)
   );

   always #5 w_clk = ~w_clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] pc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_ret = 0;
   int   cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction encoders
   function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [31:0] imm);
      return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
      return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [31:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] e_br(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] e_lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction
   function automatic logic [31:0] e_jal(input logic [4:0] rd, input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] pc, input int lat);
      exp_t e;
      e.we = we; e.rd = rd; e.data = data; e.pc = pc; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) dut.imem[i] = 32'd0;
   endtask

   // Retire monitor: samples at negedge, counts cycles since the previous retire
   always @(negedge w_clk) begin
      exp_t e;
      if (w_rst) begin
         cyc = 0;
      end else begin
         cyc++;
         if (w_retire === 1'b1) begin
            n_ret++;
            if (exp_q.size() == 0) begin
               check("unexpected_retire", {31'd0, w_retire}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("retire_pc", w_pc, e.pc);
               check("retire_lat", cyc, e.lat);
               check("wb_we", {31'd0, w_wb_we}, {31'd0, e.we});
               if (e.we) begin
                  check("rd_idx", {27'd0, w_rd_idx}, {27'd0, e.rd});
                  check("wb_data", w_wb_data, e.data);
               end
            end
            cyc = 0;
         end else if (w_wb_we !== 1'b0) begin
            check("stray_wb_we", {31'd0, w_wb_we}, 32'd0);
         end
      end
   end

   task automatic do_reset();
      w_rst = 1'b1;
      repeat (2) @(posedge w_clk);
      #1 w_rst = 1'b0;
      n_ret = 0;
      @(negedge w_clk);
      check("rst_pc", w_pc, 32'd0);
      check("rst_retire", {31'd0, w_retire}, 32'd0);
      check("rst_wb_we", {31'd0, w_wb_we}, 32'd0);
      check("rst_rd_idx", {27'd0, w_rd_idx}, 32'd0);
      check("rst_wb_data", w_wb_data, 32'd0);
      check("rst_halt", {31'd0, w_halt}, 32'd0);
   endtask

   task automatic wait_ret(input int n, input int budget);
      for (int i = 0; i < budget && n_ret < n; i++) @(posedge w_clk);
      if (n_ret < n) check("retire_timeout", n_ret, n);
   endtask

   task automatic check_halt(input logic [31:0] pc, input int n);
      repeat (n) begin
         @(negedge w_clk);
         check("halt", {31'd0, w_halt}, 32'd1);
         check("halt_pc", w_pc, pc);
      end
   endtask

   initial begin
      // Program 1: dependent ADDIs, then halt via x30
      clear_imem();
      dut.imem[0] = e_addi(5'd1, 5'd0, 32'd5);
      dut.imem[1] = e_addi(5'd2, 5'd1, 32'd7);
      dut.imem[2] = e_addi(5'd30, 5'd0, 32'd1);
      exp_q.delete();
      push(1'b1, 5'd1, 32'd5, 32'd0, LatAlu);
      push(1'b1, 5'd2, 32'd12, 32'd4, LatAlu);
      push(1'b1, 5'd30, 32'd1, 32'd8, LatAlu);
      do_reset();
      wait_ret(3, 200);
      check_halt(32'd8, 20);
      check("p1_x2", dut.rf_q[2], 32'd12);

      // Program 2: countdown loop with BNE taken twice, then fall-through
      clear_imem();
      dut.imem[0] = e_addi(5'd1, 5'd0, 32'd3);
      dut.imem[1] = e_addi(5'd1, 5'd1, 32'hFFFF_FFFF);
      dut.imem[2] = e_br(3'b001, 5'd1, 5'd0, 32'hFFFF_FFFC);
      dut.imem[3] = e_addi(5'd30, 5'd0, 32'd1);
      exp_q.delete();
      push(1'b1, 5'd1, 32'd3, 32'd0, LatAlu);
      for (int k = 2; k >= 0; k--) begin
         push(1'b1, 5'd1, k, 32'd4, LatAlu);
         push(1'b0, 5'd0, 32'd0, 32'd8, LatBr);
      end
      push(1'b1, 5'd30, 32'd1, 32'd12, LatAlu);
      do_reset();
      wait_ret(8, 400);
      check_halt(32'd12, 3);
      check("p2_x1", dut.rf_q[1], 32'd0);

      // Program 3: memory, wraparound load, x0 write, LUI, R-type, JAL, BEQ, unsupported
      clear_imem();
      dut.imem[0]  = e_addi(5'd1, 5'd0, 32'h55);
      dut.imem[1]  = e_sw(5'd1, 5'd0, 32'd8);
      dut.imem[2]  = e_lw(5'd2, 5'd0, 32'd8);
      dut.imem[3]  = e_addi(5'd9, 5'd0, 32'h123);
      dut.imem[4]  = e_sw(5'd9, 5'd0, 32'd0);
      dut.imem[5]  = e_lw(5'd4, 5'd0, 32'd256);
      dut.imem[6]  = e_addi(5'd0, 5'd0, 32'd9);
      dut.imem[7]  = e_lui(5'd3, 20'hFFFFF);
      dut.imem[8]  = e_r(7'b0000000, 5'd5, 5'd1, 5'd2);
      dut.imem[9]  = e_r(7'b0100000, 5'd6, 5'd0, 5'd1);
      dut.imem[10] = e_jal(5'd7, 32'd8);
      dut.imem[11] = e_addi(5'd8, 5'd0, 32'd1);
      dut.imem[12] = e_br(3'b000, 5'd0, 5'd0, 32'd8);
      dut.imem[13] = e_addi(5'd8, 5'd0, 32'd2);
      dut.imem[14] = 32'hFFFF_FFFF;
      dut.imem[15] = e_addi(5'd30, 5'd0, 32'd1);
      exp_q.delete();
      push(1'b1, 5'd1, 32'h55, 32'd0, LatAlu);
      push(1'b0, 5'd0, 32'd0, 32'd4, LatSw);
      push(1'b1, 5'd2, 32'h55, 32'd8, LatLw);
      push(1'b1, 5'd9, 32'h123, 32'd12, LatAlu);
      push(1'b0, 5'd0, 32'd0, 32'd16, LatSw);
      push(1'b1, 5'd4, 32'h123, 32'd20, LatLw);
      push(1'b0, 5'd0, 32'd0, 32'd24, LatAlu);
      push(1'b1, 5'd3, 32'hFFFF_F000, 32'd28, LatAlu);
      push(1'b1, 5'd5, 32'hAA, 32'd32, LatAlu);
      push(1'b1, 5'd6, 32'hFFFF_FFAB, 32'd36, LatAlu);
      push(1'b1, 5'd7, 32'd44, 32'd40, LatAlu);
      push(1'b0, 5'd0, 32'd0, 32'd48, LatBr);
      push(1'b0, 5'd0, 32'd0, 32'd56, LatAlu);
      push(1'b1, 5'd30, 32'd1, 32'd60, LatAlu);
      do_reset();
      wait_ret(14, 400);
      check_halt(32'd60, 2);
      check("p3_dmem2", dut.dmem[2], 32'h55);
      check("p3_x0", dut.rf_q[0], 32'd0);
      check("p3_x3", dut.rf_q[3], 32'hFFFF_F000);
      check("p3_x8", dut.rf_q[8], 32'd0);

      // Program 4: reset lands while SW is in MEM; the store must not happen
      clear_imem();
      dut.imem[0] = e_addi(5'd1, 5'd0, 32'h77);
      dut.imem[1] = e_sw(5'd1, 5'd0, 32'd0);
      exp_q.delete();
      push(1'b1, 5'd1, 32'h77, 32'd0, LatAlu);
      do_reset();
      wait_ret(1, 50);
      repeat (3) @(posedge w_clk);
      #1;
      exp_q.delete();
      do_reset();
      check("abort_dmem0", dut.dmem[0], 32'h123);
      check("abort_x1", dut.rf_q[1], 32'd0);
      push(1'b1, 5'd1, 32'h77, 32'd0, LatAlu);
      wait_ret(1, 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
